// File: rtl/kmeans_point_reader.sv
// Streams num_points consecutive point words from memory; first word appears 3 cycles after start.
// Reads are credit-limited against the output FIFO, so out_ready low stalls reads and never drops data.
module kmeans_point_reader #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_num_points,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [DATA_W-1:0] i_mem_rd_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 3);
   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_num;
   logic [ADDR_W:0]   r_issued;
   logic              r_busy;
   logic              r_done;
   logic              r_mem_rd_en;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_rd_last;
   logic              r_inflight;
   logic              r_inflight_last;
   logic [DATA_W-1:0] r_fifo_dat  [FIFO_DEPTH];
   logic              r_fifo_last [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_push;
   logic              w_pop;
   logic              w_credit;
   logic              w_issue;
   logic [CNT_W-1:0]  w_count_next;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_push       = r_inflight;
   assign w_pop        = o_out_valid & i_out_ready;
   assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   // The read on the bus this cycle already owns a slot, so it is counted alongside the capture
   assign w_credit     = (r_count + CNT_W'(r_inflight) + CNT_W'(r_mem_rd_en)) < CNT_W'(FIFO_DEPTH);
   assign w_issue      = (r_state == S_READ) && (r_issued < r_num) && w_credit;

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_fifo_dat[r_wr_ptr]  <= i_mem_rd_data;
         r_fifo_last[r_wr_ptr] <= r_inflight_last;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_base          <= '0;
         r_num           <= '0;
         r_issued        <= '0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_mem_rd_en     <= 1'b0;
         r_mem_addr      <= '0;
         r_rd_last       <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
      end else begin
         r_inflight      <= r_mem_rd_en;
         r_inflight_last <= r_rd_last;
         r_mem_rd_en     <= 1'b0;
         r_rd_last       <= 1'b0;
         r_done          <= 1'b0;
         r_count         <= w_count_next;
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case (r_state)
            S_IDLE: if (i_start) begin
               r_base <= i_base_addr;
               r_num  <= i_num_points;
               r_busy <= 1'b1;
               if (i_num_points != '0) begin
                  // First read leaves straight from IDLE to meet the 3-cycle start-to-data latency
                  r_mem_rd_en <= 1'b1;
                  r_mem_addr  <= i_base_addr;
                  r_issued    <= ONE;
                  r_rd_last   <= (i_num_points == ONE);
                  r_state     <= (i_num_points == ONE) ? S_DRAIN : S_READ;
               end else begin
                  r_issued <= '0;
                  r_state  <= S_DRAIN;
               end
            end
            S_READ: if (w_issue) begin
               r_mem_rd_en <= 1'b1;
               r_mem_addr  <= r_base + r_issued[ADDR_W-1:0];
               r_issued    <= r_issued + ONE;
               r_rd_last   <= (r_issued == r_num - ONE);
               if (r_issued + ONE == r_num) r_state <= S_DRAIN;
            end
            S_DRAIN: if (w_count_next == '0 && !r_inflight && !r_mem_rd_en) begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_FINISH;
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_mem_rd_en = r_mem_rd_en;
   assign o_mem_addr  = r_mem_addr;
   assign o_out_valid = (r_count != '0);
   assign o_out_data  = o_out_valid ? r_fifo_dat[r_rd_ptr] : '0;
   assign o_out_last  = o_out_valid & r_fifo_last[r_rd_ptr];
endmodule

// File: tb/tb_kmeans_point_reader.sv
// Bench for kmeans_point_reader: expected words queued at start, compared against the popped stream.
module tb_kmeans_point_reader;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 24;
   localparam int DEPTH  = 4;

   logic              clk   = 1'b0;
   logic              rst   = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base  = '0;
   logic [ADDR_W:0]   num   = '0;
   logic              ready = 1'b0;
   logic [DATA_W-1:0] rd_data = '0;
   logic              busy, done, rd_en, valid, olast;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] odat;

   int n_pass  = 0;
   int n_total = 0;

   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W:0]   obs_q[$];
   int                obs_cyc[$];
   logic [ADDR_W-1:0] addr_q[$];
   int   done_cyc, done_cnt, valid_cnt, max_occ, unstable;
   logic busy_at_done, busy_c1, timed_out, rst_bad, rst_had_valid;

   kmeans_point_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_start       (start),
      .i_base_addr   (base),
      .i_num_points  (num),
      .o_busy        (busy),
      .o_done        (done),
      .o_mem_rd_en   (rd_en),
      .o_mem_addr    (addr),
      .i_mem_rd_data (rd_data),
      .o_out_valid   (valid),
      .i_out_ready   (ready),
      .o_out_data    (odat),
      .o_out_last    (olast)
   );

   always #5 clk = ~clk;

   // Memory word equals its address; junk is returned when no read was issued
   always @(posedge clk) rd_data <= rd_en ? DATA_W'(addr) : DATA_W'($urandom);

   task automatic do_start(input logic [ADDR_W-1:0] b, input int n);
      logic [ADDR_W-1:0] a;
      exp_q.delete();
      @(negedge clk);
      start = 1'b1;
      base  = b;
      num   = (ADDR_W+1)'(n);
      for (int i = 0; i < n; i++) begin
         a = b + ADDR_W'(i);
         exp_q.push_back({(i == n - 1), DATA_W'(a)});
      end
   endtask

   // Cycle 1 is the cycle after start was sampled. Collects observations only.
   task automatic run(input int mode, input int max_cyc, input int xs_cyc, input int rst_pops);
      int   c = 0, pushes = 0, pops = 0, post = 0, occ = 0, rst_state = 0;
      logic r1 = 1'b0, r2 = 1'b0, pv = 1'b0, pr = 1'b0, rdy;
      logic [DATA_W:0] pd = '0;
      bit   stop = 1'b0;
      obs_q.delete(); obs_cyc.delete(); addr_q.delete();
      done_cyc = -1; done_cnt = 0; valid_cnt = 0; max_occ = 0; unstable = 0;
      busy_at_done = 1'b0; busy_c1 = 1'b0; timed_out = 1'b0; rst_bad = 1'b0; rst_had_valid = 1'b0;
      while (!stop) begin
         @(negedge clk);
         c++;
         if (rst_state == 1) begin
            rst = 1'b0;
            rst_bad = busy | done | rd_en | valid | olast | (addr != '0) | (odat != '0);
            rst_state = 2;
         end
         start = (c == xs_cyc);
         if (c == xs_cyc) begin
            base = 10'h200;
            num  = 11'd3;
         end
         if (c == 1) busy_c1 = busy;
         pushes += int'(r2);
         occ = pushes - pops;
         if (occ > max_occ) max_occ = occ;
         r2 = r1;
         r1 = rd_en;
         if (rd_en) addr_q.push_back(addr);
         if (valid) valid_cnt++;
         if (rst_state == 0 && pv && !pr && (!valid || {olast, odat} != pd)) unstable++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               busy_at_done = busy;
            end
         end
         case (mode)
            1:       rdy = !(c >= 4 && c <= 12);
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b1;
         endcase
         if (rst_state == 0 && rst_pops > 0 && pops == rst_pops) begin
            rst = 1'b1;
            rst_state = 1;
            rst_had_valid = valid;
            rdy = 1'b0;
         end
         ready = rdy;
         if (valid && rdy) begin
            obs_q.push_back({olast, odat});
            obs_cyc.push_back(c);
            pops++;
         end
         pv = valid;
         pr = rdy;
         pd = {olast, odat};
         if (done_cyc >= 0 || rst_state == 2) post++;
         if (post >= 6) stop = 1'b1;
         if (c >= max_cyc) begin
            timed_out = 1'b1;
            stop = 1'b1;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({busy, done, rd_en, valid, olast} !== 5'b0)
         $display("FAIL reset_ctrl: busy/done/rd_en/valid/last=%b required 00000", {busy, done, rd_en, valid, olast});
      else n_pass++;
      n_total++;
      if ({addr, odat} !== '0)
         $display("FAIL reset_data: mem_addr=%h out_data=%h required 0", addr, odat);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int bad = 0, gap = 0, no = 0, ne = 0;
      do_start(10'h010, 5);
      run(0, 100, -1, 0);
      n_total++;
      if (timed_out !== 1'b0) $display("FAIL basic_timeout: no done within budget"); else n_pass++;
      n_total++;
      if (busy_c1 !== 1'b1) $display("FAIL basic_busy: busy=%b in cycle 1 required 1", busy_c1); else n_pass++;
      foreach (obs_cyc[i]) if (obs_cyc[i] != 3 + i) gap++;
      n_total++;
      if (gap != 0 || obs_cyc.size() == 0)
         $display("FAIL basic_timing: first pop cycle %0d, %0d off-slot, required cycles 3..7", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, gap);
      else n_pass++;
      no = obs_q.size(); ne = exp_q.size();
      while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) bad++;
      n_total++;
      if (bad != 0 || no != ne) $display("FAIL basic_stream: got %0d words (%0d wrong) required %0d", no, bad, ne); else n_pass++;
      n_total++;
      if (done_cyc !== 8) $display("FAIL basic_done_cycle: got %0d required 8", done_cyc); else n_pass++;
      n_total++;
      if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done); else n_pass++;
      n_total++;
      if (done_cnt !== 1) $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      for (int m = 1; m <= 2; m++) begin
         int bad = 0, no = 0, ne = 0;
         do_start((m == 1) ? 10'h020 : 10'h040, 8);
         run(m, 400, -1, 0);
         n_total++;
         if (timed_out !== 1'b0) $display("FAIL bp_timeout mode %0d: no done within budget", m); else n_pass++;
         no = obs_q.size(); ne = exp_q.size();
         while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) bad++;
         n_total++;
         if (bad != 0 || no != ne) $display("FAIL bp_stream mode %0d: got %0d words (%0d wrong) required %0d", m, no, bad, ne); else n_pass++;
         n_total++;
         if (max_occ > DEPTH) $display("FAIL bp_occupancy mode %0d: got %0d required <= %0d", m, max_occ, DEPTH); else n_pass++;
         n_total++;
         if (unstable !== 0) $display("FAIL bp_stable mode %0d: %0d changes while stalled, required 0", m, unstable); else n_pass++;
         n_total++;
         if (addr_q.size() !== 8) $display("FAIL bp_reads mode %0d: got %0d reads required 8", m, addr_q.size()); else n_pass++;
         if (m == 1) begin
            n_total++;
            if (max_occ !== DEPTH) $display("FAIL bp_fill: peak occupancy %0d required %0d", max_occ, DEPTH); else n_pass++;
         end
      end
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] ea [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      int bad = 0, abad = 0, no = 0, ne = 0;
      do_start(10'h3FE, 4);
      run(0, 100, -1, 0);
      foreach (addr_q[i]) if (i >= 4 || addr_q[i] !== ea[i]) abad++;
      n_total++;
      if (abad != 0 || addr_q.size() != 4) $display("FAIL wrap_addr: %0d reads (%0d wrong) required 4 (3fe,3ff,000,001)", addr_q.size(), abad); else n_pass++;
      no = obs_q.size(); ne = exp_q.size();
      while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) bad++;
      n_total++;
      if (bad != 0 || no != ne) $display("FAIL wrap_stream: got %0d words (%0d wrong) required %0d", no, bad, ne); else n_pass++;
   endtask

   task automatic test_zero_count();
      do_start(10'h055, 0);
      run(0, 50, -1, 0);
      n_total++;
      if (done_cyc !== 2) $display("FAIL zero_done_cycle: got %0d required 2", done_cyc); else n_pass++;
      n_total++;
      if (addr_q.size() !== 0) $display("FAIL zero_reads: got %0d reads required 0", addr_q.size()); else n_pass++;
      n_total++;
      if (valid_cnt !== 0) $display("FAIL zero_valid: out_valid high %0d cycles required 0", valid_cnt); else n_pass++;
      n_total++;
      if (busy_c1 !== 1'b1) $display("FAIL zero_busy: busy=%b in cycle 1 required 1", busy_c1); else n_pass++;
   endtask

   task automatic test_max_count();
      int bad = 0, no = 0, ne = 0;
      logic [DATA_W:0] last_w;
      do_start(10'h000, 1024);
      run(0, 1300, -1, 0);
      n_total++;
      if (timed_out !== 1'b0) $display("FAIL max_timeout: no done within budget"); else n_pass++;
      last_w = (obs_q.size() > 0) ? obs_q[$] : '0;
      n_total++;
      if (last_w !== {1'b1, 24'h0003FF}) $display("FAIL max_last: final entry %h required 10003ff", last_w); else n_pass++;
      no = obs_q.size(); ne = exp_q.size();
      while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) bad++;
      n_total++;
      if (bad != 0 || no != 1024) $display("FAIL max_stream: got %0d words (%0d wrong) required %0d", no, bad, ne); else n_pass++;
   endtask

   task automatic test_start_while_busy();
      int bad = 0, no = 0, ne = 0;
      do_start(10'h080, 6);
      run(0, 100, 4, 0);
      no = obs_q.size(); ne = exp_q.size();
      while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) bad++;
      n_total++;
      if (bad != 0 || no != ne) $display("FAIL busy_start_stream: got %0d words (%0d wrong) required %0d", no, bad, ne); else n_pass++;
      n_total++;
      if (addr_q.size() !== 6) $display("FAIL busy_start_reads: got %0d reads required 6", addr_q.size()); else n_pass++;
      n_total++;
      if (done_cnt !== 1) $display("FAIL busy_start_done: got %0d pulses required 1", done_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int bad = 0, no = 0, ne = 0;
      do_start(10'h0C0, 6);
      run(0, 100, -1, 2);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      exp_q[1] = {1'b0, 24'h0000C1};
      n_total++;
      if (rst_had_valid !== 1'b1) $display("FAIL midrst_fifo: out_valid=%b at reset required 1", rst_had_valid); else n_pass++;
      n_total++;
      if (rst_bad !== 1'b0) $display("FAIL midrst_outputs: nonzero output=%b after reset required 0", rst_bad); else n_pass++;
      n_total++;
      if (done_cnt !== 0) $display("FAIL midrst_done: got %0d pulses required 0", done_cnt); else n_pass++;
      no = obs_q.size(); ne = exp_q.size();
      while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) bad++;
      n_total++;
      if (bad != 0 || no != ne) $display("FAIL midrst_prefix: got %0d words (%0d wrong) required %0d", no, bad, ne); else n_pass++;
      bad = 0;
      do_start(10'h100, 2);
      run(0, 100, -1, 0);
      no = obs_q.size(); ne = exp_q.size();
      while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) bad++;
      n_total++;
      if (bad != 0 || no != ne) $display("FAIL midrst_restart: got %0d words (%0d wrong) required %0d", no, bad, ne); else n_pass++;
      n_total++;
      if (done_cnt !== 1) $display("FAIL midrst_restart_done: got %0d pulses required 1", done_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_count();
      test_max_count();
      test_start_while_busy();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
